// File: rtl/seq_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_frame_tx_if
//  Brief    : Frame-request / serial-output bundle of seq_frame_tx.
//             Optional macro SEQ_FRAME_TX_CHECK_EN adds det_in / chk_err.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_frame_tx_if #(
  parameter int LEN_W = 4
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             outp;
  logic             frm_rst;
  logic             busy;
  logic             done;
`ifdef SEQ_FRAME_TX_CHECK_EN
  logic             det_in;
  logic             chk_err;
`endif

`ifdef SEQ_FRAME_TX_CHECK_EN
  // Control side: requests frames, observes the line and the checker verdict
  modport master (
    output start, len, det_in,
    input  outp, frm_rst, busy, done, chk_err
  );

  // Generator side
  modport slave (
    input  start, len, det_in,
    output outp, frm_rst, busy, done, chk_err
  );
`else
  // Control side: requests frames and observes the line
  modport master (
    output start, len,
    input  outp, frm_rst, busy, done
  );

  // Generator side
  modport slave (
    input  start, len,
    output outp, frm_rst, busy, done
  );
`endif

endinterface
`default_nettype wire

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_frame_tx
//  Brief    : Serial frame generator for the 2-bit sequence detectors.
//             Emits a one-cycle detector reset strobe, a single 0 header bit,
//             len ones, then holds the line idle-high.
//             Optional macro SEQ_FRAME_TX_CHECK_EN adds a sticky acceptance
//             checker sampling the detector output after each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_frame_tx #(
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_frame_tx_if.slave bus
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_SYNC = 3'd1;
  localparam logic [2:0] c_HDR  = 3'd2;
  localparam logic [2:0] c_RUN  = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [LEN_W-1:0] c_CNT_LAST = LEN_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] r_cnt;
  logic             r_outp;
  logic             r_frm_rst;
  logic             r_busy;
  logic             r_done;
  logic             w_outp_nxt;
  logic             w_frm_rst_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_accept;

  // A zero-length request is dropped here, so the run counter never wraps
  assign w_accept = (r_state == c_IDLE) && bus.start && (bus.len != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_SYNC;
      c_SYNC:  w_state_nxt = c_HDR;
      c_HDR:   w_state_nxt = c_RUN;
      c_RUN:   if (r_cnt == c_CNT_LAST) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so outputs can be flopped in step
  always_comb begin
    w_outp_nxt    = 1'b1;
    w_frm_rst_nxt = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      c_SYNC: begin
        w_frm_rst_nxt = 1'b1;
        w_busy_nxt    = 1'b1;
      end
      c_HDR: begin
        w_outp_nxt = 1'b0;
        w_busy_nxt = 1'b1;
      end
      c_RUN: begin
        w_busy_nxt = 1'b1;
      end
      c_DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_outp_nxt = 1'b1;
      end
    endcase
  end

  // Output flops: every output leaves the block straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outp    <= 1'b1;
      r_frm_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_outp    <= w_outp_nxt;
      r_frm_rst <= w_frm_rst_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Length capture on accept and run-length down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_q <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_len_q <= bus.len;
      end
      if (r_state == c_HDR) begin
        r_cnt <= r_len_q;
      end else if (r_state == c_RUN) begin
        r_cnt <= r_cnt - c_CNT_LAST;
      end
    end
  end

  assign bus.outp    = r_outp;
  assign bus.frm_rst = r_frm_rst;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

`ifdef SEQ_FRAME_TX_CHECK_EN
  logic r_chk_arm;
  logic r_chk_err;

  // Sticky acceptance check in the cycle after DONE; a fresh sample taken
  // together with a new accept replaces the old verdict instead of being lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_arm <= 1'b0;
      r_chk_err <= 1'b0;
    end else begin
      r_chk_arm <= (r_state == c_DONE);
      if (r_chk_arm) begin
        r_chk_err <= (w_accept ? 1'b0 : r_chk_err) | ~bus.det_in;
      end else if (w_accept) begin
        r_chk_err <= 1'b0;
      end
    end
  end

  assign bus.chk_err = r_chk_err;
`endif

endmodule
`default_nettype wire

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame generator; the transmit side of the bit-stream protocol consumed by the team's 2-bit sequence-detector FSMs.
- Accepted frame: one `0` header bit followed by one or more `1` bits, starting from detector reset.
- The block emits a frame-reset strobe, then the header, then `len` ones, then holds the line idle-high.
- Sits between test/control logic and a detector's `inp`/`rst`; drives both stimulus and frame sync.

Parameters:
- LEN_W, 4: width of the run-length request; maximum run of ones = 2^LEN_W-1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request; sampled in IDLE only.
- len  input  LEN_W  number of `1` bits after the header; captured on an accepted start.
- outp  output  1  serial bit to the detector `inp`; registered.
- frm_rst  output  1  one-cycle detector reset strobe; registered.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, outp=1, frm_rst=0, busy=0, done=0, counter=0, len_q=0. The frame in progress is abandoned; nothing resumes after reset.
- States:
  - IDLE: outp=1. `start=1 && len!=0` → len_q<=len, go to SYNC. `start=1 && len==0` is ignored; stay in IDLE and emit no strobe.
  - SYNC: frm_rst=1, outp=1 for exactly one cycle → HDR.
  - HDR: outp=0 for one cycle; counter<=len_q → RUN.
  - RUN: outp=1; counter decrements each cycle. Leave when counter==1 → DONE. RUN lasts exactly len_q cycles.
  - DONE: outp=1, done=1 for one cycle → IDLE.
- Latency: start accepted at edge E. frm_rst is high in cycle E+1, the header in E+2, ones in E+3..E+2+len, done in E+3+len.
- Total frame = len+3 cycles. Back-to-back frames: start may be held high; the next frame is accepted in the IDLE cycle after DONE. Minimum spacing is len+4 cycles.
- start and len are ignored while busy. len changes mid-frame have no effect.
- Counter is LEN_W bits. It never wraps, because len==0 is rejected at accept time.
- Idle-high line: a detector that accepted a frame stays in its accept state until the next frm_rst.
- All outputs come directly from flops; there is no combinational path from input to output.

Optional Feature:
- Macro SEQ_FRAME_TX_CHECK_EN adds an acceptance checker:
  - input det_in (1): detector `outp`.
  - output chk_err (1).
  - In the cycle after DONE, the block samples det_in. chk_err <= ~det_in (sticky).
  - chk_err clears on the next accepted start and on rst. Reset value is 0.
- Without the macro: no det_in/chk_err ports, no check logic; all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-RUN with len=5 → same cycle: outp=1, busy=0, frm_rst=0. After release with no start, outp stays 1 indefinitely.
- Basic frame: start=1 for one cycle with len=3 → frm_rst high in E+1; outp sequence from E+1 is 1,0,1,1,1,1. done pulses at E+6; busy is high E+1..E+6.
- Zero length: start with len=0 → no frm_rst, busy stays 0, outp stays 1. Then start with len=1 → outp 1,0,1,1 and done at E+4.
- Back-to-back: start held high with len=2 → second frm_rst occurs 6 cycles after the first. len changed to 7 mid-frame → the first frame still emits exactly 2 ones.
- Max length: len=15 (LEN_W=4) → exactly 15 consecutive ones after the header, no counter wrap, done at E+18.
- With SEQ_FRAME_TX_CHECK_EN, driving a detector instance:
  - len=4 → chk_err stays 0.
  - Force det_in=0 after DONE → chk_err=1, held until the next accepted start, then 0.
